// File: rtl/a2_bridge_pkg.sv
// Shared definitions for the A2 bus bridge responder and its bus master.
// Register select codes and bit positions in the sel-0 status byte.
package a2_bridge_pkg;

    localparam logic [2:0] SEL_CTRL    = 3'd0;
    localparam logic [2:0] SEL_DATA    = 3'd1;
    localparam logic [2:0] SEL_ADDR_LO = 3'd2;
    localparam logic [2:0] SEL_ADDR_HI = 3'd3;
    localparam logic [2:0] SEL_M2      = 3'd4;
    localparam logic [2:0] SEL_DIP     = 3'd5;

    localparam int CTRL_BIT_RW    = 0;
    localparam int CTRL_BIT_INH   = 1;
    localparam int CTRL_BIT_IRQ   = 2;
    localparam int CTRL_BIT_RDY   = 3;
    localparam int CTRL_BIT_DMA   = 4;
    localparam int CTRL_BIT_NMI   = 5;
    localparam int CTRL_BIT_RESET = 6;

    // Bit of the control-out byte that releases (1) or pulls (0) IRQ.
    localparam int CTRL_OUT_IRQ = 2;

endpackage

// File: rtl/a2_bridge_if.sv
// Bridge master port: register select, read/write strobes, data in/out.
// master drives the strobes and write data; slave returns read data.
interface a2_bridge_if;
    import a2_bridge_pkg::*;

    logic [2:0] bridge_sel_i;
    logic       bridge_rd_n_i;
    logic       bridge_wr_n_i;
    logic       bridge_bus_d_oe_n_i;
    logic [7:0] bridge_d_i;
    logic [7:0] bridge_d_o;
    logic       bridge_d_oe_o;

    modport master (
        output bridge_sel_i,
        output bridge_rd_n_i,
        output bridge_wr_n_i,
        output bridge_bus_d_oe_n_i,
        output bridge_d_i,
        input  bridge_d_o,
        input  bridge_d_oe_o
    );

    modport slave (
        input  bridge_sel_i,
        input  bridge_rd_n_i,
        input  bridge_wr_n_i,
        input  bridge_bus_d_oe_n_i,
        input  bridge_d_i,
        output bridge_d_o,
        output bridge_d_oe_o
    );

endinterface

// File: rtl/a2_bridge_sync.sv
// N-stage W-bit synchronizer with async active-low reset to RST_VAL.
// Ports: clk, rst_n, d (async input), q (synchronized output).
module a2_bridge_sync #(
    parameter int             STAGES  = 2,
    parameter int             W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] ff [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) ff[i] <= RST_VAL;
        end else begin
            ff[0] <= d;
            for (int i = 1; i < STAGES; i++) ff[i] <= ff[i-1];
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/a2_bridge_responder.sv
// Bridge responder: latches Apple II slot signals and serves them as bytes.
// Ports: clock/reset, Apple slot inputs, bridge bus (slave), Apple drives.
module a2_bridge_responder
    import a2_bridge_pkg::*;
#(
    parameter int PHI_SYNC_STAGES = 2
) (
    input  logic        clk_logic_i,
    input  logic        system_reset_n_i,
    input  logic        a2_phi0_i,
    input  logic [15:0] a2_addr_i,
    input  logic [7:0]  a2_data_i,
    input  logic        a2_rw_n_i,
    input  logic        a2_m2sel_n_i,
    input  logic        a2_m2b0_i,
    input  logic [5:0]  a2_control_n_i,
    input  logic [3:0]  dip_switches_n_i,
    a2_bridge_if.slave  bus,
    output logic [7:0]  a2_data_o,
    output logic        a2_data_oe_o,
    output logic        a2_irq_oe_o,
    output logic        contention_o
);

    logic        phi_s;
    logic        phi_d;
    logic [5:0]  ctrl_n_s;
    logic [3:0]  dip_n_s;

    logic [15:0] addr_r;
    logic        rw_n_r;
    logic        m2sel_n_r;
    logic        m2b0_r;
    logic [7:0]  data_r;

    logic [7:0]  ctrl_out_r;
    logic [7:0]  data_out_r;
    logic        wr_n_d;
    logic        commit;
    logic        contention_r;
    logic [7:0]  rd_mux;
    logic        ctrl_unused;

    a2_bridge_sync #(
        .STAGES (PHI_SYNC_STAGES),
        .W      (1),
        .RST_VAL(1'b0)
    ) u_sync_phi (
        .clk  (clk_logic_i),
        .rst_n(system_reset_n_i),
        .d    (a2_phi0_i),
        .q    (phi_s)
    );

    a2_bridge_sync #(
        .STAGES (PHI_SYNC_STAGES),
        .W      (6),
        .RST_VAL(6'h3F)
    ) u_sync_ctrl (
        .clk  (clk_logic_i),
        .rst_n(system_reset_n_i),
        .d    (a2_control_n_i),
        .q    (ctrl_n_s)
    );

    a2_bridge_sync #(
        .STAGES (PHI_SYNC_STAGES),
        .W      (4),
        .RST_VAL(4'hF)
    ) u_sync_dip (
        .clk  (clk_logic_i),
        .rst_n(system_reset_n_i),
        .d    (dip_switches_n_i),
        .q    (dip_n_s)
    );

    // Latch enables use the delayed PHI0 so the edge-pulse cycle still
    // loads and the freeze lands on the following cycle.
    always_ff @(posedge clk_logic_i or negedge system_reset_n_i) begin
        if (!system_reset_n_i) begin
            phi_d     <= 1'b0;
            addr_r    <= 16'h0000;
            rw_n_r    <= 1'b1;
            m2sel_n_r <= 1'b0;
            m2b0_r    <= 1'b0;
            data_r    <= 8'h00;
        end else begin
            phi_d <= phi_s;
            if (!phi_d) begin
                addr_r    <= a2_addr_i;
                rw_n_r    <= a2_rw_n_i;
                m2sel_n_r <= a2_m2sel_n_i;
                m2b0_r    <= a2_m2b0_i;
            end
            if (phi_d) begin
                data_r <= a2_data_i;
            end
        end
    end

    // One commit per wr_n low pulse, however long it is held.
    assign commit = wr_n_d && !bus.bridge_wr_n_i;

    always_ff @(posedge clk_logic_i or negedge system_reset_n_i) begin
        if (!system_reset_n_i) begin
            wr_n_d       <= 1'b1;
            ctrl_out_r   <= 8'hFF;
            data_out_r   <= 8'h00;
            contention_r <= 1'b0;
        end else begin
            wr_n_d <= bus.bridge_wr_n_i;
            if (commit && bus.bridge_sel_i == SEL_CTRL) begin
                ctrl_out_r <= bus.bridge_d_i;
            end
            if (commit && bus.bridge_sel_i == SEL_DATA) begin
                data_out_r <= bus.bridge_d_i;
            end
            if ((!bus.bridge_rd_n_i && !bus.bridge_wr_n_i) ||
                (!bus.bridge_bus_d_oe_n_i && phi_s && !rw_n_r)) begin
                contention_r <= 1'b1;
            end
        end
    end

    always_comb begin
        rd_mux = 8'hFF;
        unique case (bus.bridge_sel_i)
            SEL_CTRL:    rd_mux = {1'b1, ctrl_n_s, rw_n_r};
            SEL_DATA:    rd_mux = data_r;
            SEL_ADDR_LO: rd_mux = addr_r[7:0];
            SEL_ADDR_HI: rd_mux = addr_r[15:8];
            SEL_M2:      rd_mux = {6'b111111, m2sel_n_r, m2b0_r};
            SEL_DIP:     rd_mux = {4'hF, dip_n_s};
            default:     rd_mux = 8'hFF;
        endcase
    end

    assign bus.bridge_d_o    = bus.bridge_rd_n_i ? 8'hFF : rd_mux;
    assign bus.bridge_d_oe_o = !bus.bridge_rd_n_i && bus.bridge_wr_n_i;

    assign a2_data_o    = data_out_r;
    assign a2_data_oe_o = !bus.bridge_bus_d_oe_n_i && phi_s && rw_n_r;
    assign a2_irq_oe_o  = !ctrl_out_r[CTRL_OUT_IRQ];
    assign contention_o = contention_r;

    // Remaining control-out bits are kept for the master but drive nothing.
    assign ctrl_unused = ^{ctrl_out_r[7:3], ctrl_out_r[1:0]};

endmodule

// File: tb/tb_a2_bridge_responder.sv
// Directed bench for a2_bridge_responder: read tables plus write,
// drive, contention, DIP and reset sequences.
module tb_a2_bridge_responder;
    import a2_bridge_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        phi0;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        rw_n;
    logic        m2sel_n;
    logic        m2b0;
    logic [5:0]  ctrl_n;
    logic [3:0]  dip_n;
    logic [7:0]  a2_data_o;
    logic        a2_data_oe;
    logic        irq_oe;
    logic        contention;

    int checks = 0;
    int errors = 0;

    a2_bridge_if bif ();

    a2_bridge_responder #(.PHI_SYNC_STAGES(2)) dut (
        .clk_logic_i     (clk),
        .system_reset_n_i(rst_n),
        .a2_phi0_i       (phi0),
        .a2_addr_i       (addr),
        .a2_data_i       (data),
        .a2_rw_n_i       (rw_n),
        .a2_m2sel_n_i    (m2sel_n),
        .a2_m2b0_i       (m2b0),
        .a2_control_n_i  (ctrl_n),
        .dip_switches_n_i(dip_n),
        .bus             (bif.slave),
        .a2_data_o       (a2_data_o),
        .a2_data_oe_o    (a2_data_oe),
        .a2_irq_oe_o     (irq_oe),
        .contention_o    (contention)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] sel;
        logic [7:0] exp;
        string      nm;
    } rd_vec_t;

    rd_vec_t rv [12];

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h want %02h", nm, act, exp);
        end
    endtask

    task automatic rd_check(input int i);
        bif.bridge_sel_i  = rv[i].sel;
        bif.bridge_rd_n_i = 1'b0;
        #1;
        chk(rv[i].nm, bif.bridge_d_o, rv[i].exp);
        bif.bridge_rd_n_i = 1'b1;
        #1;
    endtask

    task automatic wr(input logic [2:0] sel, input logic [7:0] d,
                      input int cyc);
        bif.bridge_sel_i  = sel;
        bif.bridge_d_i    = d;
        bif.bridge_wr_n_i = 1'b0;
        step(cyc);
        bif.bridge_wr_n_i = 1'b1;
        step(2);
    endtask

    initial begin
        rv[0]  = '{3'd2, 8'hA5, "addr_lo_frozen"};
        rv[1]  = '{3'd3, 8'hC0, "addr_hi_frozen"};
        rv[2]  = '{3'd0, 8'hFF, "ctrl_rw1"};
        rv[3]  = '{3'd4, 8'hFD, "m2_frozen"};
        rv[4]  = '{3'd5, 8'hFF, "dip_idle"};
        rv[5]  = '{3'd6, 8'hFF, "sel6"};
        rv[6]  = '{3'd7, 8'hFF, "sel7"};
        rv[7]  = '{3'd1, 8'h5A, "data_frozen"};
        rv[8]  = '{3'd2, 8'h34, "addr_lo_phi1"};
        rv[9]  = '{3'd3, 8'h12, "addr_hi_phi1"};
        rv[10] = '{3'd4, 8'hFE, "m2_phi1"};
        rv[11] = '{3'd0, 8'hFE, "ctrl_rw0"};

        rst_n   = 1'b0;
        phi0    = 1'b0;
        addr    = 16'h0000;
        data    = 8'h00;
        rw_n    = 1'b1;
        m2sel_n = 1'b1;
        m2b0    = 1'b0;
        ctrl_n  = 6'h3F;
        dip_n   = 4'hF;
        bif.bridge_sel_i       = 3'd0;
        bif.bridge_rd_n_i      = 1'b1;
        bif.bridge_wr_n_i      = 1'b1;
        bif.bridge_bus_d_oe_n_i = 1'b1;
        bif.bridge_d_i         = 8'h00;
        step(3);

        chk("rst_d_o", bif.bridge_d_o, 8'hFF);
        chk("rst_d_oe", {7'd0, bif.bridge_d_oe_o}, 8'h00);
        chk("rst_a2_data", a2_data_o, 8'h00);
        chk("rst_a2_oe", {7'd0, a2_data_oe}, 8'h00);
        chk("rst_irq_oe", {7'd0, irq_oe}, 8'h00);
        chk("rst_contention", {7'd0, contention}, 8'h00);

        rst_n   = 1'b1;
        addr    = 16'hC0A5;
        rw_n    = 1'b1;
        m2b0    = 1'b1;
        m2sel_n = 1'b0;
        step(5);
        phi0 = 1'b1;
        step(6);
        addr    = 16'h1234;
        rw_n    = 1'b0;
        m2b0    = 1'b0;
        m2sel_n = 1'b1;
        data    = 8'h5A;
        step(2);

        bif.bridge_sel_i  = 3'd2;
        bif.bridge_rd_n_i = 1'b0;
        #1;
        chk("rd_d_oe", {7'd0, bif.bridge_d_oe_o}, 8'h01);
        bif.bridge_rd_n_i = 1'b1;
        #1;
        chk("rd_idle_ff", bif.bridge_d_o, 8'hFF);
        for (int i = 0; i < 7; i++) rd_check(i);

        phi0 = 1'b0;
        step(6);
        data = 8'h00;
        step(2);
        for (int i = 7; i < 12; i++) rd_check(i);

        wr(3'd0, 8'hFF, 1);
        chk("irq_init_ff", {7'd0, irq_oe}, 8'h00);
        wr(3'd0, 8'hFB, 1);
        chk("irq_fb", {7'd0, irq_oe}, 8'h01);
        wr(3'd0, 8'hFF, 3);
        chk("irq_ff_long", {7'd0, irq_oe}, 8'h00);

        bif.bridge_sel_i  = 3'd1;
        bif.bridge_d_i    = 8'h11;
        bif.bridge_wr_n_i = 1'b0;
        step(1);
        bif.bridge_d_i = 8'h22;
        step(2);
        bif.bridge_wr_n_i = 1'b1;
        step(2);
        chk("wr_once", a2_data_o, 8'h11);

        wr(3'd2, 8'h00, 1);
        chk("wr_sel2_irq", {7'd0, irq_oe}, 8'h00);
        chk("wr_sel2_data", a2_data_o, 8'h11);

        wr(3'd1, 8'h3C, 1);
        rw_n = 1'b1;
        step(4);
        bif.bridge_bus_d_oe_n_i = 1'b0;
        step(4);
        chk("drv_phi1_oe", {7'd0, a2_data_oe}, 8'h00);
        chk("drv_data", a2_data_o, 8'h3C);
        phi0 = 1'b1;
        step(5);
        chk("drv_phi0_oe", {7'd0, a2_data_oe}, 8'h01);
        chk("drv_no_cont", {7'd0, contention}, 8'h00);
        phi0 = 1'b0;
        step(5);
        chk("drv_fall_oe", {7'd0, a2_data_oe}, 8'h00);

        bif.bridge_bus_d_oe_n_i = 1'b1;
        rw_n = 1'b0;
        step(5);
        bif.bridge_bus_d_oe_n_i = 1'b0;
        step(2);
        chk("wcyc_phi1_cont", {7'd0, contention}, 8'h00);
        phi0 = 1'b1;
        step(5);
        chk("wcyc_oe", {7'd0, a2_data_oe}, 8'h00);
        chk("wcyc_cont", {7'd0, contention}, 8'h01);
        bif.bridge_bus_d_oe_n_i = 1'b1;
        phi0 = 1'b0;
        rw_n = 1'b1;

        rst_n = 1'b0;
        step(2);
        chk("rst2_cont", {7'd0, contention}, 8'h00);
        rst_n = 1'b1;
        step(4);

        bif.bridge_sel_i  = 3'd1;
        bif.bridge_d_i    = 8'h77;
        bif.bridge_rd_n_i = 1'b0;
        bif.bridge_wr_n_i = 1'b0;
        #1;
        chk("both_d_oe", {7'd0, bif.bridge_d_oe_o}, 8'h00);
        step(2);
        bif.bridge_rd_n_i = 1'b1;
        bif.bridge_wr_n_i = 1'b1;
        step(1);
        chk("both_commit", a2_data_o, 8'h77);
        chk("both_cont", {7'd0, contention}, 8'h01);

        dip_n  = 4'b0111;
        ctrl_n = 6'b111101;
        step(2);
        bif.bridge_sel_i  = 3'd5;
        bif.bridge_rd_n_i = 1'b0;
        #1;
        chk("dip_f7", bif.bridge_d_o, 8'hF7);
        bif.bridge_sel_i = 3'd0;
        #1;
        chk("ctrl_irq_low", bif.bridge_d_o, 8'hFB);
        bif.bridge_rd_n_i = 1'b1;
        #1;

        wr(3'd0, 8'hFB, 1);
        chk("pre_rst_irq", {7'd0, irq_oe}, 8'h01);
        bif.bridge_sel_i  = 3'd1;
        bif.bridge_d_i    = 8'h99;
        bif.bridge_wr_n_i = 1'b0;
        #1;
        rst_n = 1'b0;
        step(2);
        chk("midwr_irq", {7'd0, irq_oe}, 8'h00);
        chk("midwr_data", a2_data_o, 8'h00);
        chk("midwr_cont", {7'd0, contention}, 8'h00);
        chk("midwr_d_o", bif.bridge_d_o, 8'hFF);
        chk("midwr_a2_oe", {7'd0, a2_data_oe}, 8'h00);
        bif.bridge_wr_n_i = 1'b1;
        rst_n = 1'b1;
        step(3);
        chk("post_rst_irq", {7'd0, irq_oe}, 8'h00);
        chk("post_rst_data", a2_data_o, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
